// File: rtl/pim_cmd_receiver_if.sv
`default_nettype none
// =====================================================================
// Module   : pim_cmd_receiver_if
// Brief    : Command issue channel between the PIM command receiver
//            (master) and the PIM compute engine (slave).
// Revision : 1.0 - initial release
// =====================================================================
interface pim_cmd_receiver_if #(
    parameter int LEN = 32
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [LEN-1:0] cmd_src1;
    logic [LEN-1:0] cmd_src2;
    logic [LEN-1:0] cmd_dst;
    logic           eng_done;

    modport master (
        output cmd_valid,
        output cmd_src1,
        output cmd_src2,
        output cmd_dst,
        input  cmd_ready,
        input  eng_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_src1,
        input  cmd_src2,
        input  cmd_dst,
        output cmd_ready,
        output eng_done
    );
endinterface
`default_nettype wire

// File: rtl/pim_cmd_receiver.sv
`default_nettype none
// =====================================================================
// Module   : pim_cmd_receiver
// Brief    : Start synchroniser, command FIFO and one-outstanding issue
//            FSM for the PIM engine. Optional: PIM_CMD_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// =====================================================================
module pim_cmd_receiver #(
    parameter int LEN       = 32,
    parameter int DEPTH     = 4,
    parameter int ALIGN_LG2 = 6
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire [LEN-1:0]      src1_addr,
    input  wire [LEN-1:0]      src2_addr,
    input  wire [LEN-1:0]      dst_addr,
    input  wire                start,
    pim_cmd_receiver_if.master cmd_if,
    output logic               busy,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic [15:0]        done_cnt,
    output logic               err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 3 * LEN;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [1:0]       IDLE      = 2'd0;
    localparam logic [1:0]       ISSUE     = 2'd1;
    localparam logic [1:0]       WAIT_DONE = 2'd2;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (ALIGN_LG2 < 1) || (ALIGN_LG2 >= LEN)) begin : g_param_check
        $error("pim_cmd_receiver: DEPTH must be a power of 2 >= 2 and 0 < ALIGN_LG2 < LEN");
    end

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]      done_cnt_q, done_cnt_d;
    logic [ENT_W-1:0] head;

    logic start_pulse;
    logic misaligned;
    logic push;
    logic pop;
    logic refuse;

    assign start_pulse = s2_q & ~s3_q;
    assign pop         = (state_q == ISSUE) & cmd_if.cmd_ready;
    assign push        = start_pulse & ~misaligned & ((count_q < FULL_CNT) | pop);
    assign refuse      = start_pulse & ~misaligned & ~push;

`ifdef PIM_CMD_ALIGN_CHECK_EN
    localparam logic [LEN-1:0] ALIGN_MASK = LEN'((64'd1 << ALIGN_LG2) - 64'd1);
    logic err_q, err_d;

    assign misaligned = |((src1_addr | src2_addr | dst_addr) & ALIGN_MASK);
    assign err_d      = err_q | (start_pulse & misaligned);
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        s1_d       = start;
        s2_d       = s1_q;
        s3_d       = s2_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | refuse;
        drop_cnt_d = drop_cnt_q;
        if (refuse && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        // Addresses are stable while start is high, so sample them directly.
        if (push) begin
            mem_d[wr_ptr_q] = {src1_addr, src2_addr, dst_addr};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_if.eng_done) begin
                    state_d    = IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            done_cnt_q <= 16'd0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // The head entry is only popped on handshake, so cmd_* hold through ISSUE.
    assign head             = mem_q[rd_ptr_q];
    assign cmd_if.cmd_valid = (state_q == ISSUE);
    assign cmd_if.cmd_src1  = head[ENT_W-1 -: LEN];
    assign cmd_if.cmd_src2  = head[2*LEN-1 -: LEN];
    assign cmd_if.cmd_dst   = head[LEN-1:0];

    assign busy     = (count_q != '0) | (state_q != IDLE);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign done_cnt = done_cnt_q;
endmodule
`default_nettype wire

// File: doc/pim_cmd_receiver.md
Name: pim_cmd_receiver

Overview:
Command front end of the PIM memory. It receives matrix-multiply commands from the host/bench side, which drives a level start plus src1/src2/dst addresses that are not aligned to clk. The block synchronises and edge-detects start, captures the addresses, and buffers them in a small FIFO. It dispatches commands one at a time to the PIM compute engine over a valid/ready handshake and waits for engine completion before issuing the next command.

Parameters:
LEN, 32, address width (matches types::LEN)
DEPTH, 4, command FIFO entries (power of 2, >=2)
ALIGN_LG2, 6, log2 of required address alignment in bytes (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
src1_addr  in  LEN  source matrix 1 base address; stable before start rises and held while start is high
src2_addr  in  LEN  source matrix 2 base address; same stability rule
dst_addr  in  LEN  destination base address; same stability rule
start  in  1  asynchronous level request; each rising edge is one command
cmd_valid  out  1  command presented to the engine
cmd_ready  in  1  engine accepts the command
cmd_src1  out  LEN  head command src1
cmd_src2  out  LEN  head command src2
cmd_dst  out  LEN  head command dst
eng_done  in  1  one-cycle pulse: the issued command has completed
busy  out  1  FIFO non-empty, or FSM not in IDLE
overflow  out  1  sticky: a command was dropped because the FIFO was full
drop_cnt  out  8  number of dropped commands, saturates at 255
done_cnt  out  16  number of completed commands, wraps
err  out  1  sticky alignment error (optional feature only; otherwise tied to 0)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchroniser flops and edge register cleared.
  - FIFO emptied.
  - FSM set to IDLE.
  - All outputs 0, including cmd_* data.
  - Reset mid-command discards all queued and in-flight commands. Any eng_done arriving after reset deasserts, while in IDLE, is ignored.
- Synchronisation:
  - start passes through 2 flops (s1, s2); a third flop s3 holds the previous value.
  - start_pulse = s2 & ~s3.
  - The addresses are sampled directly into the FIFO on the start_pulse cycle. This is legal because of the stability rule.
  - A start held high for many cycles produces exactly one command.
  - A start pulse shorter than one clk period may be missed; the source must hold start for at least 2 clk periods.
- FIFO:
  - DEPTH entries of {src1, src2, dst}, with wrapping rd/wr pointers and a count register.
  - Push when start_pulse and (count<DEPTH or pop this cycle). Simultaneous push and pop while full is accepted.
  - When a push is refused: overflow<=1 and drop_cnt increments, saturating at 255. FIFO contents are unchanged.
  - Pop = cmd_valid & cmd_ready.
  - cmd_src1/src2/dst show the head entry combinationally from registered storage.
- FSM:
  - IDLE: cmd_valid=0. If count>0, go to ISSUE next cycle. A command pushed in cycle N appears as cmd_valid in cycle N+2 at the earliest.
  - ISSUE: cmd_valid=1, and the cmd_* outputs are held stable until handshake. On cmd_ready, pop and go to WAIT_DONE.
  - WAIT_DONE: cmd_valid=0. On eng_done, done_cnt increments (wrapping 0xFFFF->0) and the FSM returns to IDLE.
  - eng_done in IDLE or ISSUE is ignored and not counted.
- Ordering and output rules:
  - Strictly one outstanding command; commands issue in FIFO order.
  - busy is registered-free combinational: (count!=0) | (state!=IDLE).
  - No output is X after reset.

Optional Feature:
PIM_CMD_ALIGN_CHECK_EN
- Defined:
  - On start_pulse, if any address has a nonzero low ALIGN_LG2 bits, the command is not pushed and err<=1 (sticky until reset).
  - A misaligned command does not count as a drop and does not set overflow.
- Undefined:
  - No check is made; every command follows the normal push rules.
  - err is tied to 0.

Test Plan:
- Single command: after reset, src1=0x1000, src2=0x2000, dst=0x3000, start high for 5 cycles, cmd_ready=1, eng_done 10 cycles after handshake -> exactly one cmd_valid with those addresses; done_cnt=1; busy back to 0; overflow=0.
- Level hold: start held high for 100 cycles -> exactly one push and one command issued.
- Overflow: cmd_ready=0, 6 distinct start pulses with DEPTH=4 -> FIFO holds the first 4; overflow=1; drop_cnt=2. Then cmd_ready=1 with eng_done responses -> the 4 commands issue in order; done_cnt=4.
- Backpressure: cmd_ready low for 20 cycles while in ISSUE -> cmd_valid and cmd_src1/src2/dst remain stable; no pop; then one handshake.
- Stray done and reset: eng_done while IDLE -> done_cnt unchanged. rst_n asserted during WAIT_DONE with 2 commands queued -> all outputs 0 immediately, busy=0; later eng_done ignored.
- Alignment (macro defined, ALIGN_LG2=6): dst=0x3004 -> no push, err=1, drop_cnt=0. Then aligned 0x3040 -> issued normally.
